// File: rtl/serial_rx.sv
// serial_rx: asynchronous 8N1 receiver (MSB first) with a one-entry holding
// buffer, dsr ready handshake, and sticky framing/overrun flags.
module serial_rx #(
  parameter int unsigned BIT_PERIOD  = 106,
  parameter int unsigned HALF_PERIOD = BIT_PERIOD / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_en,
  input  logic       rx_ack,
  output logic       dsr,
  output logic [7:0] rx_data,
  output logic       rx_full,
  output logic       rx_strobe,
  output logic       frame_error,
  output logic       overrun
);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } state_t;

  localparam logic [9:0] BIT_LAST  = 10'(BIT_PERIOD - 1);
  localparam logic [9:0] HALF_LAST = 10'(HALF_PERIOD - 1);

  state_t     state;
  logic [9:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       sync1;
  logic       rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  assign dsr = rx_en && !rx_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= R_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_full     <= 1'b0;
      rx_strobe   <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      if (rx_ack && rx_full) begin
        rx_full <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        R_IDLE: begin
          if (rx_en && !rx_s) begin
            state <= R_START;
            cnt   <= '0;
          end
        end

        R_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        R_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {shreg[6:0], rx_s};
            if (bit_idx == 3'd7) state <= R_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        R_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= R_IDLE;
            // An ack on this same edge frees the buffer for the new byte.
            if (!rx_s) begin
              frame_error <= 1'b1;
            end else if (rx_full && !rx_ack) begin
              overrun <= 1'b1;
            end else begin
              rx_data     <= shreg;
              rx_full     <= 1'b1;
              rx_strobe   <= 1'b1;
              frame_error <= 1'b0;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: frame-level reference model, strobe monitor,
// directed corner cases followed by randomized frames.
module tb_serial_rx;

  localparam int unsigned BP = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_en;
  logic       rx_ack;
  logic       dsr;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_strobe;
  logic       frame_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_full;
  logic       m_fe;
  logic       m_ovr;

  serial_rx #(.BIT_PERIOD(BP)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_in      (rx_in),
    .rx_en      (rx_en),
    .rx_ack     (rx_ack),
    .dsr        (dsr),
    .rx_data    (rx_data),
    .rx_full    (rx_full),
    .rx_strobe  (rx_strobe),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must correspond to a byte the model says was accepted.
  always @(negedge clock) begin
    if (reset === 1'b0 && rx_strobe === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else check("strobe_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic model_reset();
    m_data = 8'h00;
    m_full = 1'b0;
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    check($sformatf("%s_full", tag), {31'd0, rx_full}, {31'd0, m_full});
    check($sformatf("%s_data", tag), {24'd0, rx_data}, {24'd0, m_data});
    check($sformatf("%s_ferr", tag), {31'd0, frame_error}, {31'd0, m_fe});
    check($sformatf("%s_ovr", tag), {31'd0, overrun}, {31'd0, m_ovr});
    check($sformatf("%s_dsr", tag), {31'd0, dsr}, {31'd0, rx_en && !m_full});
    check($sformatf("%s_pending", tag), exp_q.size(), 32'd0);
  endtask

  task automatic idle(input int unsigned n);
    rx_in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    if (m_full) begin
      m_full = 1'b0;
      m_ovr  = 1'b0;
    end
    @(negedge clock);
    rx_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit ack_at_stop,
                            input bit drop_en, input bit rst_mid);
    logic en0;
    en0   = rx_en;
    rx_in = 1'b0;
    repeat (BP) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      rx_in = b[7-k];
      if (drop_en && k == 2) rx_en = 1'b0;
      if (rst_mid && k == 4) begin
        reset = 1'b1;
        #1;
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_full", {31'd0, rx_full}, 32'd0);
        check("rst_strobe", {31'd0, rx_strobe}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (BP - 1) @(negedge clock);
      end else begin
        repeat (BP) @(negedge clock);
      end
    end
    rx_in = stop;
    if (drop_en) rx_en = 1'b1;
    if (en0 && !rst_mid) begin
      if (ack_at_stop && m_full) begin
        m_full = 1'b0;
        m_ovr  = 1'b0;
      end
      if (stop) begin
        if (m_full) m_ovr = 1'b1;
        else begin
          m_data = b;
          m_full = 1'b1;
          m_fe   = 1'b0;
          exp_q.push_back(b);
        end
      end else begin
        m_fe = 1'b1;
      end
    end
    // Stop is sampled 10 cycles into the stop bit (2 sync + half period).
    if (ack_at_stop) begin
      repeat (10) @(negedge clock);
      rx_ack = 1'b1;
      @(negedge clock);
      rx_ack = 1'b0;
      repeat (BP - 11) @(negedge clock);
    end else begin
      repeat (BP) @(negedge clock);
    end
    rx_in = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    bit         ack_s;
    bit         drop;

    reset  = 1'b1;
    rx_in  = 1'b1;
    rx_en  = 1'b1;
    rx_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_strobe", {31'd0, rx_strobe}, 32'd0);
    check_flags("reset");

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("a5");
    do_ack();
    check_flags("a5_ack");

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check_flags("3c_bad");
    idle(2 * BP);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("81");
    do_ack();

    rx_in = 1'b0;
    repeat (3) @(negedge clock);
    idle(2 * BP);
    check_flags("glitch");

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("overrun");
    do_ack();
    check_flags("overrun_ack");

    send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(BP);
    check_flags("after_rst");
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("5a");
    do_ack();

    rx_en = 1'b0;
    @(negedge clock);
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("en_off");
    rx_en = 1'b1;
    idle(4);
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check_flags("en_on");
    do_ack();

    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, 1'b0);
    check_flags("ack_at_stop");
    do_ack();

    for (int i = 0; i < 40; i++) begin
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 5) != 0);
      ack_s = ($urandom_range(0, 7) == 0);
      drop  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) do_ack();
      send_frame(b, stop, ack_s, drop, 1'b0);
      check_flags($sformatf("rand%0d", i));
      // A low stop bit leaves the line low; give the false start time to clear.
      idle(stop ? $urandom_range(0, 6) : BP + $urandom_range(0, 6));
    end

    idle(2 * BP);
    check("final_pending", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

Serial receiver stage that consumes the asynchronous bit stream produced by the transmitter's `data_out` line. It recovers frames of start bit (0), 8 data bits MSB first, and stop bit (1), and holds each received byte in a one-entry buffer until the consumer acknowledges it. It also drives the `dsr` ready handshake back to the transmitter and flags framing and overrun errors.

## Interface
- `BIT_PERIOD`, default 106: clock cycles per serial bit; legal range 4..1023.
- `HALF_PERIOD`, default `BIT_PERIOD/2` (floor): start-bit mid-point offset.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; forces every register to its reset value immediately.
- `rx_in` input 1: serial line, idle high.
- `rx_en` input 1: receiver enable; while low, start-bit detection is suppressed.
- `rx_ack` input 1: consumer has taken `rx_data`; clears the buffer.
- `dsr` output 1: ready to the transmitter; equals `rx_en && !rx_full`.
- `rx_data` output 8: last accepted byte.
- `rx_full` output 1: buffer holds an unacknowledged byte.
- `rx_strobe` output 1: one-cycle pulse when a byte is loaded.
- `frame_error` output 1: last frame had stop bit 0 (sticky until next good frame or reset).
- `overrun` output 1: a frame completed while `rx_full`; sticky until `rx_ack` or reset.

## Operation
- Reset values: `rx_data`=0, `rx_full`=0, `rx_strobe`=0, `frame_error`=0, `overrun`=0. FSM starts in R_IDLE with `cnt`=0 and `bit_idx`=0. Both synchronizer flops reset to 1.
- `rx_in` passes through a 2-flop synchronizer. Its output is `rx_s`, and all sampling uses `rx_s`.
- `cnt` is 10 bits wide and `bit_idx` is 3 bits wide. `shreg` is 8 bits wide and shifts left, with the new bit entering at bit 0, so the first data bit ends at bit 7.
- FSM states:
  - R_IDLE:
    - If `rx_en && rx_s==0`, go to R_START with `cnt`=0.
  - R_START:
    - `cnt`++ each cycle.
    - At `cnt==HALF_PERIOD-1`, sample `rx_s`.
    - If `rx_s==0`, go to R_DATA with `cnt`=0 and `bit_idx`=0.
    - Otherwise this is a false start; return to R_IDLE.
  - R_DATA:
    - `cnt`++ each cycle.
    - At `cnt==BIT_PERIOD-1`, shift `rx_s` into `shreg` and set `cnt`=0.
    - If `bit_idx==7`, go to R_STOP; otherwise `bit_idx`++.
  - R_STOP: at `cnt==BIT_PERIOD-1`, sample `rx_s`, then go to R_IDLE.
    - Stop bit 1 with `rx_full==0`: `rx_data`←`shreg`, `rx_full`←1, `rx_strobe`←1, `frame_error`←0.
    - Stop bit 1 with `rx_full==1`: `overrun`←1. `rx_data` is unchanged and the new byte is discarded.
    - Stop bit 0: `frame_error`←1. `rx_data` and `rx_full` are unchanged.
- `rx_ack` while `rx_full`: next edge clears `rx_full` and `overrun`. `rx_ack` while empty is ignored.
- `rx_ack` and a good stop sample in the same cycle: the ack clears the old byte, the new byte loads, `rx_full` stays 1, and no overrun is flagged.
- `rx_en` dropping mid-frame does not abort the frame; it only gates new start detection.

## Timing
- `rx_in` falling at edge T is seen in `rx_s` at T+2, and the FSM enters R_START at T+3.
- The start sample occurs `HALF_PERIOD` cycles after entering R_START. Data bit k is sampled `(k+1)*BIT_PERIOD` cycles after that.
- `rx_strobe` and `rx_full` rise on the edge that samples the stop bit. This is the stop-sample edge, about `HALF_PERIOD + 9*BIT_PERIOD` cycles after R_START entry.
- `rx_strobe` lasts exactly one cycle. `rx_full` and `rx_data` hold until `rx_ack`.
- `dsr` is combinational from registered flags, with zero extra latency.
- Earliest new-frame detection: the cycle after the R_STOP→R_IDLE transition.
- Reset asserted mid-frame: outputs return to reset values immediately and the partial byte is lost. After release, the next start bit is needed to begin a frame.

## Test plan
- Frame 0xA5 sent with `BIT_PERIOD`=16 and `rx_en`=1 → one `rx_strobe` pulse, `rx_data`=0xA5, `rx_full`=1, `dsr`=0, `frame_error`=0. Then `rx_ack` → `rx_full`=0, `dsr`=1.
- Frame 0x3C with the stop bit driven 0 → `frame_error`=1, `rx_full`=0, and `rx_data` keeps its previous value. A following good 0x81 → `frame_error`=0, `rx_data`=0x81.
- 3-cycle low glitch on idle `rx_in` with `BIT_PERIOD`=16 → FSM returns to R_IDLE, no strobe, no error.
- Frames 0x11 then 0x22 with no ack → `rx_data`=0x11, `overrun`=1. Then `rx_ack` → `overrun`=0, `rx_full`=0.
- Reset pulsed during data bit 4 of 0xFF → all outputs 0 and FSM in R_IDLE. A subsequent 0x5A frame → `rx_data`=0x5A.
- `rx_en`=0 while a full 0x77 frame is sent → no strobe, `dsr`=0. Raise `rx_en` and send 0x77 → received correctly.
